// File: rtl/adxl345_spi_responder.sv
// ADXL345-style SPI mode-3 slave with a 64x8 register file, burst access and a
// fabric-side axis sample port. All SPI pins are oversampled on clk.
`timescale 1ns/1ps
module adxl345_spi_responder #(
  parameter int         SCLK_MIN_DIV = 8,
  parameter logic [7:0] DEVID_VAL    = 8'hE5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CS,
  input  logic        spi_clk,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        sample_valid,
  input  logic [15:0] axis_x,
  input  logic [15:0] axis_y,
  input  logic [15:0] axis_z,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic [7:0]  txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_e;

  state_e      state_q, state_d;
  logic        cs_s1_q, cs_s2_q, sck_s1_q, sck_s2_q, sck_prev_q, mosi_s1_q, mosi_s2_q;
  logic [1:0]  warm_q;
  logic        armed_q;
  logic [2:0]  bit_q, bit_d;
  logic [6:0]  sh_q, sh_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d, mb_q, mb_d;
  logic [5:0]  addr_q, addr_d;
  logic        miso_q, miso_d;
  logic        wr_stb_q, wr_stb_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  txn_q, txn_d;
  logic [7:0]  regs_q [64];
  logic        pend_q;
  logic [15:0] pend_x_q, pend_y_q, pend_z_q;
  logic [7:0]  phase_q;

  logic        active, sck_rise, sck_fall, reg_we, ax_load;
  logic [7:0]  byte_in;
  logic [5:0]  next_addr;
  logic [15:0] ax_x, ax_y, ax_z;

  function automatic logic writable(input logic [5:0] a);
    return !((a == 6'h00) || (a == 6'h30) || ((a >= 6'h32) && (a <= 6'h37)));
  endfunction

  // armed_q blocks a transaction that was already under way when reset released
  assign active    = armed_q & ~cs_s2_q;
  assign sck_rise  = sck_s2_q & ~sck_prev_q;
  assign sck_fall  = ~sck_s2_q & sck_prev_q;
  assign byte_in   = {sh_q, mosi_s2_q};
  assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;

  assign MISO      = miso_q;
  assign wr_strobe = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = active;
  assign txn_count = txn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      sck_s1_q   <= 1'b1;
      sck_s2_q   <= 1'b1;
      sck_prev_q <= 1'b1;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      warm_q     <= 2'd0;
      armed_q    <= 1'b0;
    end else begin
      cs_s1_q    <= CS;
      cs_s2_q    <= cs_s1_q;
      sck_s1_q   <= spi_clk;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      mosi_s1_q  <= MOSI;
      mosi_s2_q  <= mosi_s1_q;
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
      if ((warm_q == 2'd2) && cs_s2_q) armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    mb_d      = mb_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    txn_d     = txn_q;
    reg_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        tx_d   = 8'h00;
        bit_d  = 3'd0;
        if (active) state_d = S_CMD;
      end
      S_CMD, S_DATA: begin
        if (!active) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
          if (state_q == S_DATA) txn_d = txn_q + 8'd1;
        end else if (sck_rise) begin
          sh_d  = {sh_q[5:0], mosi_s2_q};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (state_q == S_CMD) begin
              rw_d    = byte_in[7];
              mb_d    = byte_in[6];
              addr_d  = byte_in[5:0];
              tx_d    = regs_q[byte_in[5:0]];
              state_d = S_DATA;
            end else begin
              if (!rw_q && writable(addr_q)) begin
                reg_we    = 1'b1;
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = byte_in;
              end
              addr_d = next_addr;
              tx_d   = regs_q[next_addr];
            end
          end
        end else if (sck_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_q     <= 3'd0;
      sh_q      <= 7'd0;
      tx_q      <= 8'h00;
      rw_q      <= 1'b0;
      mb_q      <= 1'b0;
      addr_q    <= 6'd0;
      miso_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 6'd0;
      wr_data_q <= 8'h00;
      txn_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      mb_q      <= mb_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      txn_q     <= txn_d;
    end
  end

  // A direct idle sample overrides a pending one landing in the same cycle
  always_comb begin
    ax_load = !active && (sample_valid || pend_q);
    ax_x    = sample_valid ? axis_x : pend_x_q;
    ax_y    = sample_valid ? axis_y : pend_y_q;
    ax_z    = sample_valid ? axis_z : pend_z_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) regs_q[i] <= 8'h00;
      regs_q[6'h00] <= DEVID_VAL;
      regs_q[6'h2C] <= 8'h0A;
      pend_q        <= 1'b0;
      pend_x_q      <= 16'h0000;
      pend_y_q      <= 16'h0000;
      pend_z_q      <= 16'h0000;
    end else begin
      if (reg_we) regs_q[addr_q] <= byte_in;
      if (ax_load) begin
        regs_q[6'h32] <= ax_x[7:0];
        regs_q[6'h33] <= ax_x[15:8];
        regs_q[6'h34] <= ax_y[7:0];
        regs_q[6'h35] <= ax_y[15:8];
        regs_q[6'h36] <= ax_z[7:0];
        regs_q[6'h37] <= ax_z[15:8];
        pend_q        <= 1'b0;
      end
      if (sample_valid && active) begin
        pend_q   <= 1'b1;
        pend_x_q <= axis_x;
        pend_y_q <= axis_y;
        pend_z_q <= axis_z;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= 8'd0;
    else if (sck_rise || sck_fall) phase_q <= 8'd0;
    else if (phase_q != 8'hFF) phase_q <= phase_q + 8'd1;
  end

  a_sclk_phase: assert property (@(posedge clk) disable iff (rst)
    (active && (sck_rise || sck_fall)) |-> ((int'(phase_q) + 1) >= (SCLK_MIN_DIV / 2)));

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Randomized bench for adxl345_spi_responder against a transaction-level register model.
`timescale 1ns/1ps
module tb_adxl345_spi_responder;
  logic        clk = 1'b0;
  logic        rst, CS, spi_clk, MOSI, MISO, sample_valid;
  logic [15:0] axis_x, axis_y, axis_z;
  logic        wr_strobe, busy;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data, txn_count;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  model [64];
  int          txn_exp;
  bit          pend;
  logic [15:0] pend_x, pend_y, pend_z;
  logic [13:0] stb_log [$];
  logic        prev_stb = 1'b0;
  logic [7:0]  wq [$];
  int          inj_after;
  logic [15:0] inj_x, inj_y, inj_z;

  adxl345_spi_responder #(.SCLK_MIN_DIV(8), .DEVID_VAL(8'hE5)) dut (
    .clk(clk), .rst(rst), .CS(CS), .spi_clk(spi_clk), .MOSI(MOSI), .MISO(MISO),
    .sample_valid(sample_valid), .axis_x(axis_x), .axis_y(axis_y), .axis_z(axis_z),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit ro_addr(input logic [5:0] a);
    return (a == 6'h00) || (a == 6'h30) || ((a >= 6'h32) && (a <= 6'h37));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    model[0]  = 8'hE5;
    model[44] = 8'h0A;
    txn_exp   = 0;
    pend      = 0;
  endfunction

  function automatic void model_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    model[50] = x[7:0]; model[51] = x[15:8];
    model[52] = y[7:0]; model[53] = y[15:8];
    model[54] = z[7:0]; model[55] = z[15:8];
  endfunction

  always @(negedge clk) begin
    if (wr_strobe) begin
      check("strobe_width", {31'd0, prev_stb}, 32'd0);
      stb_log.push_back({wr_addr, wr_data});
    end
    prev_stb = wr_strobe;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_clk = 1'b0; MOSI = b[i];
      tick(8);
      r[i] = MISO;
      spi_clk = 1'b1;
      tick(8);
    end
  endtask

  task automatic send_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    axis_x = x; axis_y = y; axis_z = z; sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    model_sample(x, y, z);
    tick(2);
  endtask

  task automatic txn(input bit rw, input bit mb, input logic [5:0] a0, input int n, input int part);
    logic [7:0]  r;
    logic [5:0]  a;
    logic [7:0]  d [$];
    logic [7:0]  exp_rd [$];
    logic [13:0] exp_wr [$];
    a = a0;
    for (int i = 0; i < n; i++) begin
      d.push_back((i < wq.size()) ? wq[i] : 8'($urandom));
      if (rw) exp_rd.push_back(model[a]);
      else if (!ro_addr(a)) begin
        model[a] = d[i];
        exp_wr.push_back({a, d[i]});
      end
      if (mb) a = a + 6'd1;
    end
    wq.delete();
    stb_log.delete();
    CS = 1'b0;
    tick(6);
    check("busy_hi", {31'd0, busy}, 32'd1);
    spi_byte({rw, mb, a0}, 8, r);
    for (int i = 0; i < n; i++) begin
      spi_byte(d[i], 8, r);
      if (rw) check($sformatf("rd%0d_a%0h", i, a0), {24'd0, r}, {24'd0, exp_rd[i]});
      if (inj_after == i + 1) begin
        axis_x = inj_x; axis_y = inj_y; axis_z = inj_z; sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        pend = 1; pend_x = inj_x; pend_y = inj_y; pend_z = inj_z;
      end
    end
    if (part > 0) spi_byte(8'hA5, part, r);
    tick(6);
    CS = 1'b1;
    tick(8);
    txn_exp++;
    if (pend) begin
      model_sample(pend_x, pend_y, pend_z);
      pend = 0;
    end
    inj_after = 0;
    check("busy_lo", {31'd0, busy}, 32'd0);
    check("txn_count", {24'd0, txn_count}, 32'(txn_exp[7:0]));
    check("strobe_cnt", stb_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < stb_log.size(); i++)
      check("strobe_addr_data", {18'd0, stb_log[i]}, {18'd0, exp_wr[i]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},  {31'd0, MISO},      32'd0);
    check({tag, "_wrstb"}, {31'd0, wr_strobe}, 32'd0);
    check({tag, "_wradr"}, {26'd0, wr_addr},   32'd0);
    check({tag, "_wrdat"}, {24'd0, wr_data},   32'd0);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_txn"},   {24'd0, txn_count}, 32'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    rst = 1'b1; CS = 1'b1; spi_clk = 1'b1; MOSI = 1'b0; sample_valid = 1'b0;
    axis_x = 16'h0; axis_y = 16'h0; axis_z = 16'h0; inj_after = 0;
    inj_x = 16'h0; inj_y = 16'h0; inj_z = 16'h0;
    model_reset();
    tick(3);
    check_reset_outputs("rst0");
    rst = 1'b0;
    tick(6);

    txn(1, 0, 6'h00, 1, 0);
    send_sample(16'h0123, 16'hFF80, 16'h4000);
    txn(1, 1, 6'h32, 6, 0);

    wq = {8'h0B}; txn(0, 0, 6'h31, 1, 0);
    txn(1, 0, 6'h31, 1, 0);
    wq = {8'h55}; txn(0, 0, 6'h00, 1, 0);
    txn(1, 0, 6'h00, 1, 0);

    inj_x = 16'h1111; inj_y = 16'h2222; inj_z = 16'h3333; inj_after = 2;
    txn(1, 1, 6'h32, 6, 0);
    txn(1, 1, 6'h32, 2, 0);

    wq = {8'h5A, 8'hC3}; txn(0, 1, 6'h3F, 2, 0);
    txn(1, 1, 6'h3F, 2, 0);
    txn(1, 0, 6'h31, 3, 0);

    txn(0, 0, 6'h2C, 0, 4);
    txn(1, 0, 6'h2C, 1, 0);

    stb_log.delete();
    CS = 1'b0; tick(6);
    spi_byte(8'h6C, 4, r);
    tick(6); CS = 1'b1; tick(8);
    check("cmd_abort_txn", {24'd0, txn_count}, 32'(txn_exp[7:0]));
    check("cmd_abort_stb", stb_log.size(), 0);

    for (int k = 0; k < 16; k++) begin
      bit         rw, mb;
      logic [5:0] a;
      int         n;
      rw = 1'($urandom); mb = 1'($urandom); a = 6'($urandom); n = 1 + $urandom_range(3);
      if ($urandom_range(3) == 0) send_sample(16'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(4) == 0) begin
        inj_x = 16'($urandom); inj_y = 16'($urandom); inj_z = 16'($urandom);
        inj_after = 1 + $urandom_range(n - 1);
      end
      txn(rw, mb, a, n, 0);
    end
    txn(1, 1, 6'h32, 6, 0);

    CS = 1'b0; tick(6);
    spi_byte(8'hF2, 8, r);
    spi_byte(8'h00, 8, r);
    spi_byte(8'h00, 3, r);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("rst_mid");
    tick(3);
    rst = 1'b0;
    tick(4);
    stb_log.delete();
    spi_byte(8'h6C, 8, r);
    spi_byte(8'h99, 8, r);
    tick(6); CS = 1'b1; tick(8);
    check("post_rst_txn", {24'd0, txn_count}, 32'd0);
    check("post_rst_stb", stb_log.size(), 0);
    model_reset();
    txn(1, 0, 6'h00, 1, 0);
    txn(1, 1, 6'h2C, 1, 0);
    txn(1, 1, 6'h32, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
